// File: rtl/data_bus_responder_pkg.sv
// Shared types for the data bus responder.
// Size and state encodings plus the default memory map.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;

  typedef struct packed {
    logic        wr;
    logic        bad;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  function automatic logic align_fault(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic f;
    unique case (size)
      SIZE_BYTE: f = 1'b0;
      SIZE_HALF: f = lane[0];
      SIZE_WORD: f = |lane;
      default:   f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Load/store bus between the data bus controller
// and the data RAM responder.
interface data_bus_responder_if;
  logic        wd;
  logic        rd;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        busy;
  logic        ack;
  logic        fault;

  modport master (
    output wd, rd, size, addr, data_in,
    input  data_out, ready, busy, ack, fault
  );

  modport slave (
    input  wd, rd, size, addr, data_in,
    output data_out, ready, busy, ack, fault
  );
endinterface

// File: rtl/data_byte_lane_ram.sv
// Word-organised RAM with per-byte write enables
// and a registered read port.
module data_byte_lane_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // byte-lane write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // registered read word
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data bus target: range/alignment checks, wait states,
// byte/half/word access to the data RAM.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          DATA_ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int          WAIT_STATES     = 0
) (
  input  logic clk,
  input  logic rst,
  data_bus_responder_if.slave bus
);

  localparam int AW = DATA_ADDR_WIDTH;
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR =
    LO_ADDR + (33'd4 << AW);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e state_q, state_d;
  req_t   req_in, req_q, req_cur;
  logic [3:0] cnt_q;
  logic accept, go_resp;
  logic in_range, cur_fault;
  logic we, re;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;
  logic [31:0] shifted, mask;
  logic [1:0]  fmt_size, fmt_lane;
  logic        fmt_zero, fault_q;

  // capture the live request
  always_comb begin
    req_in.wr   = bus.wd & ~bus.rd;
    req_in.bad  = bus.wd & bus.rd;
    req_in.size = bus.size;
    req_in.addr = bus.addr;
    req_in.data = bus.data_in;
  end

  assign accept = (state_q == ST_IDLE) &
                  (bus.wd | bus.rd);

  // zero wait states access the RAM on the accept edge
  assign req_cur = (state_q == ST_IDLE) ? req_in : req_q;

  assign go_resp =
    (accept & (WAIT_STATES == 0)) |
    ((state_q == ST_WAIT) & (cnt_q == 4'd0));

  assign in_range =
    ({1'b0, req_cur.addr} >= LO_ADDR) &
    ({1'b0, req_cur.addr} <  HI_ADDR);

  assign cur_fault = req_cur.bad | ~in_range |
    align_fault(req_cur.size, req_cur.addr[1:0]);

  assign widx = req_cur.addr[AW+1:2] - BASE_ADDR[AW+1:2];

  assign we = go_resp & ~rst & req_cur.wr & ~cur_fault;
  assign re = go_resp & ~rst & ~req_cur.wr & ~cur_fault;

  // lane enables and replicated write data
  always_comb begin
    be    = 4'b1111;
    wdata = req_cur.data;
    unique case (1'b1)
      req_cur.size == SIZE_BYTE: begin
        be    = 4'b0001 << req_cur.addr[1:0];
        wdata = {4{req_cur.data[7:0]}};
      end
      req_cur.size == SIZE_HALF: begin
        be    = req_cur.addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_cur.data[15:0]}};
      end
      default: ;
    endcase
  end

  data_byte_lane_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (widx),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept)
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.ready = (state_q == ST_IDLE);
    bus.busy  = (state_q == ST_WAIT) |
                (state_q == ST_RESP);
    bus.ack   = (state_q == ST_RESP);
    bus.fault = (state_q == ST_RESP) & fault_q;
  end

  // request latch and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      req_q <= req_in;
      cnt_q <= WS_LOAD;
    end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // response format, fixed on the edge entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_zero <= 1'b1;
      fmt_size <= '0;
      fmt_lane <= '0;
      fault_q  <= 1'b0;
    end else if (go_resp) begin
      fmt_zero <= cur_fault;
      fmt_size <= req_cur.size;
      fmt_lane <= req_cur.addr[1:0];
      fault_q  <= cur_fault;
    end
  end

  assign shifted = rdata >> {fmt_lane, 3'b000};

  // right-justify and zero-fill read data
  always_comb begin
    mask = 32'hFFFF_FFFF;
    unique case (1'b1)
      fmt_size == SIZE_BYTE: mask = 32'h0000_00FF;
      fmt_size == SIZE_HALF: mask = 32'h0000_FFFF;
      default: ;
    endcase
    bus.data_out = fmt_zero ? 32'h0 : (shifted & mask);
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed plan plus
// random traffic against a byte-level memory model.
module tb_data_bus_responder;
  import data_bus_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int n_tests = 0;
  int n_fail  = 0;

  data_bus_responder_if bus0 ();
  data_bus_responder_if bus1 ();

  data_bus_responder #(.WAIT_STATES(0)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0)
  );

  data_bus_responder #(.WAIT_STATES(3)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );

  logic [7:0] mdl [longint];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic longint key(input int sel,
                                 input logic [31:0] a);
    return longint'(sel) * 64'h1_0000_0000 + longint'(a);
  endfunction

  function automatic bit model_fault(
    input bit w, input bit r,
    input logic [1:0] sz, input logic [31:0] a);
    longint la = longint'(a);
    if (w && r) return 1;
    if (sz == 2'd3) return 1;
    if (sz == 2'd1 && la % 2 != 0) return 1;
    if (sz == 2'd2 && la % 4 != 0) return 1;
    if (la < 64'h1000) return 1;
    if (la >= 64'h1000 + 4 * 1024) return 1;
    return 0;
  endfunction

  task automatic drive(input int sel, input bit w,
                       input bit r, input logic [1:0] sz,
                       input logic [31:0] a,
                       input logic [31:0] d);
    if (sel == 0) begin
      bus0.wd = w; bus0.rd = r; bus0.size = sz;
      bus0.addr = a; bus0.data_in = d;
    end else begin
      bus1.wd = w; bus1.rd = r; bus1.size = sz;
      bus1.addr = a; bus1.data_in = d;
    end
  endtask

  // one complete access through the model and DUT
  task automatic access(input int sel, input bit w,
                        input bit r, input logic [1:0] sz,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input string tag,
                        output logic [31:0] dout);
    int ws = (sel == 0) ? 0 : 3;
    int n = 1 << sz;
    bit f_exp = model_fault(w, r, sz, a);
    bit known = 1;
    bit got = 0;
    int lat = 0;
    logic flt = 1'bx;
    logic [31:0] exp_d = '0;
    dout = 'x;
    if (!f_exp && !w) begin
      for (int i = 0; i < n; i++) begin
        if (mdl.exists(key(sel, a + i)))
          exp_d |= 32'(mdl[key(sel, a + i)]) << (8 * i);
        else known = 0;
      end
    end
    @(negedge clk);
    check({tag, "_ready"},
          sel ? bus1.ready : bus0.ready, 1);
    drive(sel, w, r, sz, a, d);
    for (int k = 1; k <= ws + 6 && !got; k++) begin
      @(negedge clk);
      if ((sel ? bus1.ack : bus0.ack) === 1'b1) begin
        got  = 1;
        lat  = k;
        dout = sel ? bus1.data_out : bus0.data_out;
        flt  = sel ? bus1.fault : bus0.fault;
        drive(sel, 0, 0, 2'd0, 32'h0, 32'h0);
      end
    end
    if (!got) drive(sel, 0, 0, 2'd0, 32'h0, 32'h0);
    check({tag, "_lat"}, lat, ws + 1);
    check({tag, "_fault"}, flt, f_exp);
    if (f_exp)
      check({tag, "_zero"}, dout, 0);
    else if (!w && known)
      check({tag, "_data"}, dout, exp_d);
    if (w && !r && !f_exp) begin
      for (int i = 0; i < n; i++)
        mdl[key(sel, a + i)] = 8'(d >> (8 * i));
    end
  endtask

  logic [31:0] q;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'd0, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    check("rst0_ready", bus0.ready, 1);
    check("rst0_busy",  bus0.busy, 0);
    check("rst0_ack",   bus0.ack, 0);
    check("rst0_fault", bus0.fault, 0);
    check("rst0_dout",  bus0.data_out, 0);
    check("rst1_ready", bus1.ready, 1);
    check("rst1_dout",  bus1.data_out, 0);

    access(0, 1, 0, 2'd2, 32'h1000, 32'hDEADBEEF, "w_word", q);
    access(0, 0, 1, 2'd2, 32'h1000, 0, "r_word", q);
    check("r_word_const", q, 32'hDEADBEEF);
    access(0, 1, 0, 2'd0, 32'h1002, 32'h5A, "w_byte", q);
    access(0, 0, 1, 2'd2, 32'h1000, 0, "r_word2", q);
    check("r_word2_const", q, 32'hDE5ABEEF);
    access(0, 0, 1, 2'd0, 32'h1003, 0, "r_byte", q);
    check("r_byte_const", q, 32'h0000_00DE);
    access(0, 0, 1, 2'd1, 32'h1002, 0, "r_half", q);
    check("r_half_const", q, 32'h0000_DE5A);

    access(0, 0, 1, 2'd1, 32'h1001, 0, "f_half", q);
    access(0, 1, 0, 2'd2, 32'h0FFC, 32'h12345678, "f_low", q);
    access(0, 0, 1, 2'd3, 32'h1000, 0, "f_rsvd", q);
    access(0, 1, 1, 2'd2, 32'h1000, 32'h0BADF00D, "f_both", q);
    access(0, 0, 1, 2'd2, 32'h1000, 0, "r_after_f", q);
    check("r_after_f_const", q, 32'hDE5ABEEF);

    access(0, 1, 0, 2'd2, 32'h1FFC, 32'hA5A5C3C3, "w_top", q);
    access(0, 0, 1, 2'd2, 32'h1FFC, 0, "r_top", q);
    check("r_top_const", q, 32'hA5A5C3C3);
    access(0, 1, 0, 2'd2, 32'h2000, 32'h1, "f_top", q);

    // wait-state timing, changed request ignored while busy
    access(1, 1, 0, 2'd2, 32'h1008, 32'h01020304, "ws_w1", q);
    access(1, 1, 0, 2'd2, 32'h100C, 32'h55667788, "ws_w2", q);
    @(negedge clk);
    drive(1, 0, 1, 2'd2, 32'h1008, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ws_busy%0d", k), bus1.busy, k <= 4);
      check($sformatf("ws_ready%0d", k), bus1.ready, k >= 5);
      check($sformatf("ws_ack%0d", k), bus1.ack, k == 4);
      if (k == 2)
        drive(1, 1, 0, 2'd2, 32'h100C, 32'hBAD0BAD0);
      if (k == 4) begin
        check("ws_data", bus1.data_out, 32'h01020304);
        check("ws_fault", bus1.fault, 0);
        drive(1, 0, 0, 2'd0, 32'h0, 32'h0);
      end
    end
    access(1, 0, 1, 2'd2, 32'h100C, 0, "ws_ign", q);
    check("ws_ign_const", q, 32'h55667788);

    // reset in the middle of a waited write
    access(1, 1, 0, 2'd2, 32'h1004, 32'hCAFEF00D, "rm_pre", q);
    @(negedge clk);
    drive(1, 1, 0, 2'd2, 32'h1004, 32'h11223344);
    @(negedge clk);
    check("rm_ack1", bus1.ack, 0);
    @(negedge clk);
    check("rm_ack2", bus1.ack, 0);
    rst1 = 1'b1;
    drive(1, 0, 0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst1 = 1'b0;
    check("rm_ready", bus1.ready, 1);
    check("rm_busy", bus1.busy, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rm_noack%0d", k), bus1.ack, 0);
    end
    access(1, 0, 1, 2'd2, 32'h1004, 0, "rm_rd", q);
    check("rm_rd_const", q, 32'hCAFEF00D);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      int sel = $urandom_range(0, 1);
      int op  = $urandom_range(0, 9);
      int am  = $urandom_range(0, 7);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a;
      if (am <= 4)
        a = 32'h1000 + 4 * $urandom_range(0, 15)
            + $urandom_range(0, 3);
      else if (am == 5)
        a = 32'h1FF0 + $urandom_range(0, 15);
      else if (am == 6)
        a = 32'h0FF0 + $urandom_range(0, 15);
      else
        a = $urandom;
      access(sel, op < 4 || op == 9, op >= 4,
             sz, a, $urandom, $sformatf("rnd%0d", t), q);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
